// File: rtl/poly_mau_sink.sv
// poly_mau_sink
// -----------------------------------------------------------------------------
// Result sink for the POLY_MAU datapath. Every {o1,o0} pair flagged by the MAU
// with poly_valid is captured into a small first-word-fall-through FIFO and
// drained downstream over a valid/ready stream. The MAU is never stalled: a
// result arriving while the FIFO is full and not being popped is dropped and
// the sticky overflow flag is raised.
//
// Side outputs:
//   count    - accepted pushes, saturating at 16'hFFFF
//   overflow - sticky, set when a result is dropped
//   trig     - registered one-cycle pulse when count becomes trig_target (!= 0)
//   checksum - running sum of accepted o0 values mod q
//
// Optional feature macro: POLY_MAU_SINK_CHECKSUM_EN
//   defined   : mod-q accumulator is built and drives checksum
//   undefined : no accumulator, checksum is tied to zero
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous clear (FIFO, count, overflow, checksum)
//   in_valid        MAU poly_valid
//   in_o0, in_o1    MAU output lanes, W bits each
//   q               modulus, held stable
//   out_valid       FIFO non-empty
//   out_ready       downstream accepts the head entry
//   out_data        {o1,o0} of the head entry
//   level           occupancy 0..DEPTH
//   count           accepted push counter
//   overflow        sticky drop flag
//   trig_target     count value that fires trig, 0 disables
//   trig            one-cycle trigger pulse
//   checksum        mod-q sum of accepted o0 values
//
// Handshake: a downstream transfer happens on every rising edge where
// out_valid && out_ready are both high (and clr is low); out_data holds
// steady while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module poly_mau_sink #(
    parameter int DEPTH = 8,
    parameter int W     = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic [W-1:0]            in_o0,
    input  logic [W-1:0]            in_o1,
    input  logic [23:0]             q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             count,
    output logic                    overflow,
    input  logic [15:0]             trig_target,
    output logic                    trig,
    output logic [23:0]             checksum
);

    localparam int AW = $clog2(DEPTH);

    logic [2*W-1:0] mem_q [DEPTH];

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0]  count_q, count_d;
    logic         overflow_q, overflow_d;
    logic         trig_q, trig_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop  = !empty && out_ready && !clr;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = in_valid && !clr && (!full || pop);
    assign drop = in_valid && !clr && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Fire only on an actual count change so a held or saturated count
    // matching the target does not re-trigger.
    always_comb begin
        trig_d = (count_d != count_q) && (trig_target != 16'd0) &&
                 (count_d == trig_target);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            trig_q     <= trig_d;
        end
    end

    // Storage is cleared on reset so out_data reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_o1, in_o0};
        end
    end

    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign level     = wr_ptr_q - rd_ptr_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign trig      = trig_q;

`ifdef POLY_MAU_SINK_CHECKSUM_EN
    logic [23:0] cks_q, cks_d;
    logic [23:0] o0_24;
    logic [24:0] cks_sum;

    assign o0_24 = 24'(in_o0);

    // Both operands are below q, so one conditional subtract reduces mod q.
    always_comb begin
        cks_sum = {1'b0, cks_q} + {1'b0, o0_24};
        cks_d   = cks_q;
        if (clr) begin
            cks_d = '0;
        end else if (push) begin
            if (cks_sum >= {1'b0, q}) begin
                cks_d = 24'(cks_sum - {1'b0, q});
            end else begin
                cks_d = cks_sum[23:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign checksum = cks_q;
`else
    // The modulus only feeds the accumulator; keep it visibly consumed.
    logic unused_q;
    assign unused_q = ^q;
    assign checksum = 24'd0;
`endif

endmodule

// File: tb/tb_poly_mau_sink.sv
// Testbench for poly_mau_sink: table-driven single-cycle vectors followed by
// hand-written sequences for overflow, streaming, trigger, checksum, clear and
// asynchronous reset.
module tb_poly_mau_sink;

    localparam int DEPTH = 8;
    localparam int W     = 24;
    localparam logic [23:0] QMOD = 24'd8380417;

    // clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             clr;
    logic             in_valid;
    logic [W-1:0]     in_o0;
    logic [W-1:0]     in_o1;
    logic [23:0]      q;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_data;
    logic [3:0]       level;
    logic [15:0]      count;
    logic             overflow;
    logic [15:0]      trig_target;
    logic             trig;
    logic [23:0]      checksum;

    poly_mau_sink #(.DEPTH(DEPTH), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_o0       (in_o0),
        .in_o1       (in_o1),
        .q           (q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .count       (count),
        .overflow    (overflow),
        .trig_target (trig_target),
        .trig        (trig),
        .checksum    (checksum)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic        v;
        logic [23:0] o0;
        logic [23:0] o1;
        logic        rdy;
        logic        c;
        logic        ev;
        logic [47:0] ed;
        logic [3:0]  el;
        logic [15:0] ec;
        logic        eov;
        logic [23:0] ecks;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] cks_exp(input logic [23:0] v);
`ifdef POLY_MAU_SINK_CHECKSUM_EN
        return v;
`else
        return 24'd0 & v;
`endif
    endfunction

    // driver: apply inputs, take one rising edge, settle past the edge
    task automatic step(input logic v, input logic [23:0] o0, input logic [23:0] o1,
                        input logic rdy, input logic c);
        in_valid  = v;
        in_o0     = o0;
        in_o1     = o1;
        out_ready = rdy;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] sum;
        int          max_lev;
        int          trig_cnt;
        logic [23:0] o0v;
        logic [23:0] o1v;

        clr = 1'b0; in_valid = 1'b0; in_o0 = '0; in_o1 = '0;
        q = QMOD; out_ready = 1'b0; trig_target = 16'd0;

        vecs[0] = '{1'b1, 24'd5,  24'd9,  1'b0, 1'b0, 1'b1, {24'd9, 24'd5},   4'd1, 16'd1, 1'b0, 24'd5};
        vecs[1] = '{1'b1, 24'd7,  24'd1,  1'b0, 1'b0, 1'b1, {24'd9, 24'd5},   4'd2, 16'd2, 1'b0, 24'd12};
        vecs[2] = '{1'b0, 24'd0,  24'd0,  1'b1, 1'b0, 1'b1, {24'd1, 24'd7},   4'd1, 16'd2, 1'b0, 24'd12};
        vecs[3] = '{1'b1, 24'd3,  24'd4,  1'b1, 1'b0, 1'b1, {24'd4, 24'd3},   4'd1, 16'd3, 1'b0, 24'd15};
        vecs[4] = '{1'b0, 24'd0,  24'd0,  1'b1, 1'b0, 1'b0, 48'd0,            4'd0, 16'd3, 1'b0, 24'd15};
        vecs[5] = '{1'b1, 24'd11, 24'd12, 1'b1, 1'b0, 1'b1, {24'd12, 24'd11}, 4'd1, 16'd4, 1'b0, 24'd26};
        vecs[6] = '{1'b1, 24'd1,  24'd1,  1'b1, 1'b1, 1'b0, 48'd0,            4'd0, 16'd0, 1'b0, 24'd0};
        vecs[7] = '{1'b1, 24'd2,  24'd2,  1'b0, 1'b0, 1'b1, {24'd2, 24'd2},   4'd1, 16'd1, 1'b0, 24'd2};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_trig", 64'(trig), 64'd0);
        chk("rst_checksum", 64'(checksum), 64'd0);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].v, vecs[i].o0, vecs[i].o1, vecs[i].rdy, vecs[i].c);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].ed));
            chk($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].el));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].ec));
            chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].eov));
            chk($sformatf("vec%0d_checksum", i), 64'(checksum), 64'(cks_exp(vecs[i].ecks)));
            chk($sformatf("vec%0d_trig", i), 64'(trig), 64'd0);
        end

        // overflow: 9 pushes into a stalled FIFO, then drain in order
        step(1'b0, 24'd0, 24'd0, 1'b0, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 24'(100 + i), 24'(200 + i), 1'b0, 1'b0);
            if (i < 8) exp_q.push_back({24'(200 + i), 24'(100 + i)});
            if (i == 7) chk("ovf_pre_flag", 64'(overflow), 64'd0);
        end
        chk("ovf_level", 64'(level), 64'd8);
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_checksum", 64'(checksum), 64'(cks_exp(24'd828)));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_drain%0d", k), 64'(out_data), 64'(exp_q.pop_front()));
            step(1'b0, 24'd0, 24'd0, 1'b1, 1'b0);
        end
        chk("ovf_drained_level", 64'(level), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // streaming: 100 results with out_ready held high
        step(1'b0, 24'd0, 24'd0, 1'b1, 1'b1);
        exp_q.delete();
        sum = 24'd0;
        max_lev = 0;
        for (int i = 0; i < 100; i++) begin
            o0v = 24'(i * 3 + 1);
            o1v = 24'(i ^ 24'h5A5A);
            step(1'b1, o0v, o1v, 1'b1, 1'b0);
            exp_q.push_back({o1v, o0v});
            sum = sum + o0v;
            if (int'(level) > max_lev) max_lev = int'(level);
            if (out_valid) chk($sformatf("stream_data%0d", i), 64'(out_data), 64'(exp_q.pop_front()));
        end
        step(1'b0, 24'd0, 24'd0, 1'b1, 1'b0);
        chk("stream_max_level_ok", 64'(max_lev <= DEPTH), 64'd1);
        chk("stream_all_out", 64'(exp_q.size()), 64'd0);
        chk("stream_level", 64'(level), 64'd0);
        chk("stream_overflow", 64'(overflow), 64'd0);
        chk("stream_count", 64'(count), 64'd100);
        chk("stream_checksum", 64'(checksum), 64'(cks_exp(sum)));

        // trigger: target 3, five pushes
        step(1'b0, 24'd0, 24'd0, 1'b1, 1'b1);
        trig_target = 16'd3;
        trig_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 24'(i), 24'(i), 1'b1, 1'b0);
            if (trig) trig_cnt++;
            chk($sformatf("trig_push%0d", i), 64'(trig), 64'(i == 3));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 24'd0, 24'd0, 1'b1, 1'b0);
            if (trig) trig_cnt++;
        end
        chk("trig_pulses", 64'(trig_cnt), 64'd1);
        trig_target = 16'd0;

        // checksum wrap at q-1 + 2
        step(1'b0, 24'd0, 24'd0, 1'b1, 1'b1);
        step(1'b1, 24'd8380416, 24'd0, 1'b1, 1'b0);
        chk("cks_first", 64'(checksum), 64'(cks_exp(24'd8380416)));
        step(1'b1, 24'd2, 24'd0, 1'b1, 1'b0);
        chk("cks_wrap", 64'(checksum), 64'(cks_exp(24'd1)));

        // clear coincident with a push at level 4 (overflow set beforehand)
        step(1'b0, 24'd0, 24'd0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 24'(i + 1), 24'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 24'd0, 24'd0, 1'b1, 1'b0);
        chk("clr_pre_level", 64'(level), 64'd4);
        chk("clr_pre_overflow", 64'(overflow), 64'd1);
        step(1'b1, 24'd77, 24'd66, 1'b0, 1'b1);
        chk("clr_level", 64'(level), 64'd0);
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_overflow", 64'(overflow), 64'd0);
        chk("clr_checksum", 64'(checksum), 64'd0);
        step(1'b1, 24'd4, 24'd8, 1'b0, 1'b0);
        chk("post_clr_count", 64'(count), 64'd1);
        chk("post_clr_data", 64'(out_data), 64'({24'd8, 24'd4}));

        // asynchronous reset mid-stream
        step(1'b1, 24'd9, 24'd9, 1'b0, 1'b0);
        step(1'b1, 24'd10, 24'd10, 1'b0, 1'b0);
        trig_target = 16'd3;
        step(1'b1, 24'd11, 24'd11, 1'b0, 1'b0);
        chk("mid_count", 64'(count), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_trig", 64'(trig), 64'd0);
        chk("arst_checksum", 64'(checksum), 64'd0);
        in_valid = 1'b0;
        trig_target = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 24'd3, 24'd6, 1'b0, 1'b0);
        chk("after_rst_data", 64'(out_data), 64'({24'd6, 24'd3}));
        chk("after_rst_count", 64'(count), 64'd1);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
